// File: rtl/hex_word_writer_pkg.sv
// hex_word_pkg
//   Shared constants and types for the hex word writer.
//   DATA_W : width of one stored word
//   DEPTH  : number of words in the operand memory (one 4096-bit operand)
//   ADDR_W : address width, clog2(DEPTH)
//   LEN_W  : width of the load length / word counter (must hold DEPTH itself)
//   state_t: writer FSM states
//   len_legal(): true when a requested load length is within 1..DEPTH

package hex_word_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;
    localparam int LEN_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic logic len_legal(input logic [LEN_W-1:0] l);
        return (l != '0) && (l <= LEN_W'(DEPTH));
    endfunction

endpackage

// File: rtl/hex_word_writer_sdp_ram.sv
// sdp_ram
//   Simple dual-port word memory: one write port, one registered read port.
//   The read is read-first: a write and a read to the same address in the
//   same cycle returns the previous contents; the new word appears on the
//   next read. Memory contents are never cleared; srst only clears the
//   read output register.
//
//   Ports:
//     clk     : rising-edge clock
//     srst    : synchronous active-high reset (read register only)
//     we      : write enable
//     wr_addr : write address
//     wr_data : write data
//     rd_addr : read address
//     rd_data : mem[rd_addr], one cycle later

module sdp_ram
    import hex_word_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int WORDS = DEPTH,
    parameter int AW    = ADDR_W
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [WORDS];
    logic [WIDTH-1:0] rd_data_reg;

    // Write port kept in its own process, free of reset, so the array maps
    // onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of the array in the same edge as the write gives
    // read-first behaviour.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/hex_word_writer.sv
// hex_word_writer
//   Loads a stream of operand words (valid/ready) into a DEPTH x DATA_W
//   memory starting at address 0, then pulses done. A registered read port
//   lets downstream datapath blocks fetch any word at any time.
//
//   Optional feature: define HEX_WORD_WRITER_CSUM_EN to add output csum,
//   the running XOR of all accepted words of the current/last load.
//
//   Ports:
//     clk      : rising-edge clock
//     reset    : synchronous active-high reset
//     start    : one-cycle pulse, begins a load of len words at address 0
//     len      : words to load, legal range 1..DEPTH
//     in_valid : in_data holds a word
//     in_data  : word to store
//     in_ready : writer accepts a word this cycle
//     busy     : load in progress
//     done     : one-cycle pulse the cycle after the last word is written
//     err      : one-cycle pulse after a start with an illegal len
//     wr_count : words written in the current or last load
//     rd_addr  : read address
//     rd_data  : mem[rd_addr], registered (one-cycle latency, read-first)
//     csum     : (HEX_WORD_WRITER_CSUM_EN only) XOR of accepted words

module hex_word_writer
    import hex_word_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  wr_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
`ifdef HEX_WORD_WRITER_CSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);

    state_t             state_reg;
    logic               in_ready_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               err_reg;
    logic [LEN_W-1:0]   wr_count_reg;
    logic [LEN_W-1:0]   len_reg;
`ifdef HEX_WORD_WRITER_CSUM_EN
    logic [DATA_W-1:0]  csum_reg;
`endif

    logic               xfer;
    logic               last_xfer;
    logic [ADDR_W-1:0]  wr_addr;
    logic [LEN_W-1:0]   wr_count_next;

    // in_ready_reg is only ever set in LOAD, so it doubles as the state
    // qualifier for a transfer.
    assign xfer = in_valid && in_ready_reg;

    // The write pointer always equals the count of words written so far, so
    // the low bits of wr_count serve as the address. On the final word of a
    // full-depth load the count reaches DEPTH but no further write happens,
    // so the address never wraps into a live write.
    assign wr_addr       = wr_count_reg[ADDR_W-1:0];
    assign wr_count_next = wr_count_reg + LEN_W'(1);
    assign last_xfer     = (wr_count_next == len_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            wr_count_reg <= '0;
            len_reg      <= '0;
`ifdef HEX_WORD_WRITER_CSUM_EN
            csum_reg     <= '0;
`endif
        end else begin
            // done and err are single-cycle pulses.
            done_reg <= 1'b0;
            err_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    in_ready_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    if (start) begin
                        if (len_legal(len)) begin
                            len_reg      <= len;
                            wr_count_reg <= '0;
`ifdef HEX_WORD_WRITER_CSUM_EN
                            csum_reg     <= '0;
`endif
                            in_ready_reg <= 1'b1;
                            busy_reg     <= 1'b1;
                            state_reg    <= LOAD;
                        end else begin
                            // Illegal length: flag it, keep wr_count.
                            err_reg <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    // start is deliberately not looked at here.
                    if (xfer) begin
                        wr_count_reg <= wr_count_next;
`ifdef HEX_WORD_WRITER_CSUM_EN
                        csum_reg     <= csum_reg ^ in_data;
`endif
                        if (last_xfer) begin
                            in_ready_reg <= 1'b0;
                            busy_reg     <= 1'b0;
                            done_reg     <= 1'b1;
                            state_reg    <= FIN;
                        end
                    end
                end

                FIN: begin
                    in_ready_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end

                default: begin
                    in_ready_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    sdp_ram #(
        .WIDTH (DATA_W),
        .WORDS (DEPTH),
        .AW    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .srst    (reset),
        .we      (xfer),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign in_ready = in_ready_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign wr_count = wr_count_reg;
`ifdef HEX_WORD_WRITER_CSUM_EN
    assign csum     = csum_reg;
`endif

endmodule

// File: tb/tb_hex_word_writer.sv
// tb_hex_word_writer
//   Directed, table-driven bench for hex_word_writer. Inputs change 1 ns
//   after a rising edge; outputs are sampled at that same point, i.e. they
//   show the result of the edge just taken.

module tb_hex_word_writer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  wr_count;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data;
`ifdef HEX_WORD_WRITER_CSUM_EN
    logic [31:0] csum;
`endif

    int n_total = 0;
    int n_pass  = 0;

    hex_word_writer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .wr_count (wr_count),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
`ifdef HEX_WORD_WRITER_CSUM_EN
        ,
        .csum     (csum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        start;
        logic [7:0]  len;
        logic        valid;
        logic [31:0] data;
        logic [6:0]  rd_addr;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_ready;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_err;
        logic [7:0]  exp_wr;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic s, input logic [7:0] l, input logic v,
                                input logic [31:0] d, input logic [6:0] ra,
                                input logic cr, input logic [31:0] er,
                                input logic ey, input logic eb, input logic ed,
                                input logic ee, input logic [7:0] ew);
        vec_t r;
        r.start = s; r.len = l; r.valid = v; r.data = d; r.rd_addr = ra;
        r.chk_rd = cr; r.exp_rd = er; r.exp_ready = ey; r.exp_busy = eb;
        r.exp_done = ed; r.exp_err = ee; r.exp_wr = ew;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_ctl(input string tag, input logic ey, input logic eb,
                           input logic ed, input logic ee, input logic [7:0] ew);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(ey));
        chk({tag, ".busy"},     32'(busy),     32'(eb));
        chk({tag, ".done"},     32'(done),     32'(ed));
        chk({tag, ".err"},      32'(err),      32'(ee));
        chk({tag, ".wr_count"}, 32'(wr_count), 32'(ew));
    endtask

    initial begin
        logic early_done;

        reset = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
        in_data = 32'd0; rd_addr = 7'd0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("reset.rd_data", rd_data, 32'd0);
        reset = 1'b0;
        tick();
        $display("txn reset: in_ready=%b busy=%b wr_count=%0d", in_ready, busy, wr_count);

        // ---------------- full load, len=128 ----------------
        start = 1'b1; len = 8'd128;
        tick();
        start = 1'b0;
        chk_ctl("full.start", 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
        early_done = 1'b0;
        for (int i = 0; i < 128; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA000_0000 + 32'(i);
            tick();
            if (i < 127) early_done = early_done | done;
        end
        in_valid = 1'b0;
        chk("full.no_early_done", 32'(early_done), 32'd0);
        chk_ctl("full.fin", 1'b0, 1'b0, 1'b1, 1'b0, 8'd128);
        $display("txn full load: done=%b wr_count=%0d", done, wr_count);
        tick();
        chk("full.done_one_cycle", 32'(done), 32'd0);
        for (int a = 0; a < 128; a++) begin
            rd_addr = 7'(a);
            tick();
            chk($sformatf("full.rd[%0d]", a), rd_data, 32'hA000_0000 + 32'(a));
        end
        $display("txn full readback: 128 words read");

        // ---------------- table: illegal len, gaps, start ignored, readback -------
        //            st len  v  data          ra cr exp_rd        rdy bsy dn er wr
        tbl[0]  = mk(1, 0,   0, 32'h0,       0, 0, 32'h0,        0,  0,  0, 1, 128);
        tbl[1]  = mk(1, 129, 0, 32'h0,       0, 0, 32'h0,        0,  0,  0, 1, 128);
        tbl[2]  = mk(0, 0,   0, 32'h0,       0, 0, 32'h0,        0,  0,  0, 0, 128);
        tbl[3]  = mk(1, 4,   0, 32'h0,       0, 0, 32'h0,        1,  1,  0, 0, 0);
        tbl[4]  = mk(0, 0,   1, 32'h11,      0, 0, 32'h0,        1,  1,  0, 0, 1);
        tbl[5]  = mk(1, 2,   0, 32'h99,      0, 0, 32'h0,        1,  1,  0, 0, 1);
        tbl[6]  = mk(0, 0,   1, 32'h22,      0, 0, 32'h0,        1,  1,  0, 0, 2);
        tbl[7]  = mk(0, 0,   0, 32'h98,      0, 0, 32'h0,        1,  1,  0, 0, 2);
        tbl[8]  = mk(0, 0,   1, 32'h33,      0, 0, 32'h0,        1,  1,  0, 0, 3);
        tbl[9]  = mk(0, 0,   1, 32'h44,      0, 0, 32'h0,        0,  0,  1, 0, 4);
        tbl[10] = mk(0, 0,   1, 32'h55,      0, 0, 32'h0,        0,  0,  0, 0, 4);
        tbl[11] = mk(0, 0,   0, 32'h0,       0, 1, 32'h11,       0,  0,  0, 0, 4);
        tbl[12] = mk(0, 0,   0, 32'h0,       1, 1, 32'h22,       0,  0,  0, 0, 4);
        tbl[13] = mk(0, 0,   0, 32'h0,       2, 1, 32'h33,       0,  0,  0, 0, 4);
        tbl[14] = mk(0, 0,   0, 32'h0,       3, 1, 32'h44,       0,  0,  0, 0, 4);
        tbl[15] = mk(0, 0,   0, 32'h0,       4, 1, 32'hA000_0004, 0, 0,  0, 0, 4);

        for (int r = 0; r < 16; r++) begin
            start = tbl[r].start; len = tbl[r].len; in_valid = tbl[r].valid;
            in_data = tbl[r].data; rd_addr = tbl[r].rd_addr;
            tick();
            chk_ctl($sformatf("tbl[%0d]", r), tbl[r].exp_ready, tbl[r].exp_busy,
                    tbl[r].exp_done, tbl[r].exp_err, tbl[r].exp_wr);
            if (tbl[r].chk_rd) chk($sformatf("tbl[%0d].rd_data", r), rd_data, tbl[r].exp_rd);
            $display("txn tbl[%0d]: start=%b len=%0d valid=%b data=%h -> rdy=%b busy=%b done=%b err=%b wr=%0d rd=%h",
                     r, start, len, in_valid, in_data, in_ready, busy, done, err, wr_count, rd_data);
        end
        start = 1'b0; in_valid = 1'b0;

        // ---------------- read-write collision on address 2 ----------------
        start = 1'b1; len = 8'd4; rd_addr = 7'd0;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h1111_1111; tick();
        in_data = 32'h2222_2222; tick();
        in_data = 32'h5555_5555; rd_addr = 7'd2; tick();
        chk("coll.old_word", rd_data, 32'h33);
        in_data = 32'h4444_4444; tick();
        chk("coll.new_word", rd_data, 32'h5555_5555);
        chk("coll.done", 32'(done), 32'd1);
        in_valid = 1'b0;
        $display("txn collision: rd_data=%h done=%b", rd_data, done);
        tick();

`ifdef HEX_WORD_WRITER_CSUM_EN
        // ---------------- checksum, start ignored while busy ----------------
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 32'h0F0F_0F0F; tick();
        start = 1'b1; len = 8'd1; in_data = 32'hF0F0_F0F0; tick();
        chk("csum.start_ignored.err", 32'(err), 32'd0);
        start = 1'b0; in_data = 32'hFFFF_0000; tick();
        in_valid = 1'b0;
        chk("csum.done", 32'(done), 32'd1);
        chk("csum.wr_count", 32'(wr_count), 32'd3);
        chk("csum.value", csum, 32'h0000_FFFF);
        tick();
        chk("csum.stable", csum, 32'h0000_FFFF);
        $display("txn csum: csum=%h wr_count=%0d", csum, wr_count);
`endif

        // ---------------- reset in the middle of a load ----------------
        start = 1'b1; len = 8'd8;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'hC0 + 32'(i);
            tick();
        end
        chk("mid.wr_before_reset", 32'(wr_count), 32'd3);
        in_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_ctl("mid.reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        early_done = 1'b0;
        for (int a = 0; a < 3; a++) begin
            rd_addr = 7'(a);
            tick();
            early_done = early_done | done | busy;
            chk($sformatf("mid.rd[%0d]", a), rd_data, 32'hC0 + 32'(a));
        end
        chk("mid.no_done_after_reset", 32'(early_done), 32'd0);
        $display("txn reset mid-load: busy=%b wr_count=%0d", busy, wr_count);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
